ft_rx_fifo_writer: RTL and testbench
====================================

# ft_rx_fifo_writer

Receive-side bridge from the FT2232H synchronous-FIFO (FT245-style) host port to the write port of the design's dual-clock FIFO. It runs entirely in the FT2232H CLKOUT domain (wclk, 60 MHz) and drives OE#/RD# to pull host bytes. A 2-entry skid buffer absorbs the one-cycle registered-strobe overrun, so every byte read from the host is written to the FIFO in order, with no loss or duplication.

## Interface
Parameters:
- DSIZE, 8, data width of the host bus and the FIFO write data.
- CNT_W, 32, width of the accepted-byte counter.

Ports:
- wclk  in  1  FT2232H CLKOUT; also the FIFO write clock.
- wrst_n  in  1  asynchronous, active-low reset.
- en_i  in  1  synchronous enable; when low, no new read burst starts.
- ft_rxf_n_i  in  1  host data available, active low.
- ft_data_i  in  DSIZE  host data bus.
- ft_oe_n_o  out  1  host output enable, active low, registered.
- ft_rd_n_o  out  1  host read strobe, active low, registered.
- wr_en_o  out  1  FIFO write enable.
- wr_data_o  out  DSIZE  FIFO write data (skid head).
- wr_full_i  in  1  FIFO full, wclk domain.
- wr_awfull_i  in  1  FIFO almost full, wclk domain.
- busy_o  out  1  state != IDLE or skid count != 0.
- rx_count_o  out  CNT_W  bytes accepted from the host, wraps modulo 2^CNT_W.

## Operation
- Accept rule: a byte is captured at a wclk edge iff, at that edge, the registered ft_rd_n_o == 0 and ft_rxf_n_i == 0. The byte is pushed into the skid tail and rx_count_o increments.
- Skid buffer: 2 entries, FIFO order, with count cnt in 0..2.
- wr_en_o = (cnt != 0) && !wr_full_i, combinational from cnt and wr_full_i. wr_data_o = head entry.
  - A drain (wr_en_o high) and a capture at the same edge are both honoured.
  - cnt_next = cnt + capture - drain.
- State machine:
  - IDLE: oe_n=1, rd_n=1. Go to OE when en_i && !ft_rxf_n_i && cnt==0 && !wr_full_i && !wr_awfull_i.
  - OE: oe_n=0, rd_n=1, one bus-turnaround cycle. Go to READ if !ft_rxf_n_i; otherwise go to IDLE.
  - READ: oe_n=0, rd_n=0. Go to IDLE, with oe_n and rd_n both high from the next edge, when any of the following holds at the edge: ft_rxf_n_i==1, cnt_next==2, wr_full_i, wr_awfull_i, or !en_i. Otherwise stay.
- Overrun bound: rd_n is registered, so at most one byte is captured after the exit decision. cnt never exceeds 2, and a capture is never dropped.
- en_i low during READ ends the burst via the normal exit. Bytes already in the skid still drain.
- Reset, including mid-burst: state=IDLE, ft_oe_n_o=1, ft_rd_n_o=1, cnt=0 (skid contents discarded), rx_count_o=0, wr_en_o=0, wr_data_o=0, busy_o=0.

## Timing
- Host-capture to FIFO-write latency:
  - A byte captured at edge k with the FIFO not full has wr_en_o high in cycle k..k+1 and commits at edge k+1.
  - A byte behind an undrained entry commits one edge later.
- Streaming with FIFO space: 1 byte per clock sustained, cnt held at 1.
- Burst start: RXF# low seen at edge n gives OE# low after n, RD# low after n+1, first capture at n+2.
- Burst stop on RXF# high at edge m: no capture at m; RD#/OE# high after m.
- Throttle: wr_awfull_i or wr_full_i high at edge m gives RD# high after m. The capture at m is still taken.
- Re-entry needs cnt==0. The minimum IDLE dwell is 1 cycle.

## Test plan
- Burst of 16 bytes 0x00..0x0F with RXF# low and FIFO empty: OE# falls 1 cycle before RD#; 16 writes in order; rx_count_o=16; busy_o falls 1 cycle after the last write.
- Assert wr_full_i for 5 cycles mid-stream at byte 0x05: RD# rises and cnt reaches 2 (bytes 0x05, 0x06) without overflow. On release, 0x05 then 0x06 write, the burst restarts, and the full 0x00..0x0F sequence is intact.
- RXF# toggles high for 1 cycle during READ: exit to IDLE, re-enter via OE. No duplicated or missing bytes across 32 random-gap bytes.
- en_i deasserted during READ: at most 1 further byte captured, then OE#/RD# high. Skid drains and busy_o goes to 0. No new burst while en_i=0 despite RXF# low.
- wrst_n asserted during READ with cnt=2: ft_oe_n_o=ft_rd_n_o=1, wr_en_o=0, rx_count_o=0 immediately. After release, the next burst starts cleanly.
- rx_count_o at 2^CNT_W-1 plus one capture wraps to 0 (use CNT_W=4 in the bench).

Source files
------------

// File: rtl/ft_rx_fifo_writer.sv
// ft_rx_fifo_writer: pulls bytes from the FT2232H sync-FIFO host port into the dual-clock FIFO write port
module ft_rx_fifo_writer #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 32
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             en_i,
    input  logic             ft_rxf_n_i,
    input  logic [DSIZE-1:0] ft_data_i,
    output logic             ft_oe_n_o,
    output logic             ft_rd_n_o,
    output logic             wr_en_o,
    output logic [DSIZE-1:0] wr_data_o,
    input  logic             wr_full_i,
    input  logic             wr_awfull_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] rx_count_o
);
    typedef enum logic [1:0] {IDLE, OE, READ} state_t;
    state_t state, state_next;
    logic [1:0] cnt, cnt_next, pos;
    logic [DSIZE-1:0] skid0, skid1;
    logic capture, start, stop;

    assign capture   = !ft_rd_n_o && !ft_rxf_n_i;
    assign wr_en_o   = (cnt != 2'd0) && !wr_full_i;
    assign wr_data_o = skid0;
    assign cnt_next  = cnt + {1'b0, capture} - {1'b0, wr_en_o};
    assign pos       = cnt - {1'b0, wr_en_o};
    assign busy_o    = (state != IDLE) || (cnt != 2'd0);
    assign start     = en_i && !ft_rxf_n_i && cnt == 2'd0 && !wr_full_i && !wr_awfull_i;
    assign stop      = ft_rxf_n_i || cnt_next == 2'd2 || wr_full_i || wr_awfull_i || !en_i;

    // next state: one turnaround cycle with OE# low before RD# is pulled
    always_comb begin
        state_next = IDLE;
        state_next = state == IDLE ? (start ? OE : IDLE) :
                     state == OE   ? (ft_rxf_n_i ? IDLE : READ) :
                     state == READ ? (stop ? IDLE : READ) : IDLE;
    end

    // state register; host strobes are registered straight from the next state
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= IDLE;
            ft_oe_n_o <= 1'b1;
            ft_rd_n_o <= 1'b1;
        end else begin
            state     <= state_next;
            ft_oe_n_o <= state_next == IDLE;
            ft_rd_n_o <= state_next != READ;
        end
    end

    // skid buffer: a drain shifts the tail to the head, a capture lands behind whatever remains
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            cnt        <= '0;
            skid0      <= '0;
            skid1      <= '0;
            rx_count_o <= '0;
        end else begin
            cnt        <= cnt_next;
            rx_count_o <= rx_count_o + CNT_W'(capture);
            if (wr_en_o) skid0 <= skid1;
            if (capture && pos == 2'd0) skid0 <= ft_data_i;
            if (capture && pos != 2'd0) skid1 <= ft_data_i;
        end
    end
endmodule

// File: tb/tb_ft_rx_fifo_writer.sv
// tb_ft_rx_fifo_writer: host model feeds bytes, scoreboard checks FIFO writes, counter and strobe protocol
module tb_ft_rx_fifo_writer;
    localparam int DSIZE = 8;
    localparam int CNT_W = 4;

    logic wclk = 1'b0, wrst_n = 1'b1, en_i = 1'b0, ft_rxf_n_i = 1'b1;
    logic wr_full_i = 1'b0, wr_awfull_i = 1'b0;
    logic [DSIZE-1:0] ft_data_i = '0;
    logic ft_oe_n_o, ft_rd_n_o, wr_en_o, busy_o;
    logic [DSIZE-1:0] wr_data_o;
    logic [CNT_W-1:0] rx_count_o;

    logic [DSIZE-1:0] host_q[$];
    logic [DSIZE-1:0] exp_q[$];
    int cap_total = 0, gap_pct = 0, thr_pct = 0, pass_cnt = 0, total_cnt = 0;
    logic will_cap = 1'b0;

    always #5 wclk = ~wclk;

    ft_rx_fifo_writer #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .en_i(en_i), .ft_rxf_n_i(ft_rxf_n_i),
        .ft_data_i(ft_data_i), .ft_oe_n_o(ft_oe_n_o), .ft_rd_n_o(ft_rd_n_o),
        .wr_en_o(wr_en_o), .wr_data_o(wr_data_o), .wr_full_i(wr_full_i),
        .wr_awfull_i(wr_awfull_i), .busy_o(busy_o), .rx_count_o(rx_count_o)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endfunction

    function automatic void check_reset(input string tag);
        check({tag, "_oe"}, 32'(ft_oe_n_o), 32'(1));
        check({tag, "_rd"}, 32'(ft_rd_n_o), 32'(1));
        check({tag, "_wr_en"}, 32'(wr_en_o), 32'(0));
        check({tag, "_wr_data"}, 32'(wr_data_o), 32'(0));
        check({tag, "_rx_count"}, 32'(rx_count_o), 32'(0));
        check({tag, "_busy"}, 32'(busy_o), 32'(0));
    endfunction

    // host model: consumes a byte whenever RD# and RXF# were both low at the edge, then presents the next
    task automatic cyc();
        @(negedge wclk);
        if (will_cap) begin
            exp_q.push_back(host_q.pop_front());
            cap_total++;
        end
        ft_rxf_n_i = host_q.size() == 0 || $urandom_range(99) < 32'(gap_pct);
        ft_data_i = host_q.size() != 0 ? host_q[0] : DSIZE'($urandom);
        if (thr_pct != 0) begin
            wr_full_i = $urandom_range(99) < 32'(thr_pct);
            wr_awfull_i = $urandom_range(99) < 32'(thr_pct);
        end
        will_cap = wrst_n && !ft_rd_n_o && !ft_rxf_n_i;
    endtask

    task automatic run_idle(input string name, input int limit);
        logic done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            cyc();
            done = host_q.size() == 0 && exp_q.size() == 0 && !busy_o && !will_cap;
        end
        thr_pct = 0;
        wr_full_i = 1'b0;
        wr_awfull_i = 1'b0;
        check({name, "_done"}, 32'(done), 32'(1));
    endtask

    task automatic wait_rd(input string name);
        for (int i = 0; i < 50 && ft_rd_n_o; i++) cyc();
        check({name, "_rd_low"}, 32'(ft_rd_n_o), 32'(0));
    endtask

    // monitor: pre-edge view of every cycle, compares writes against the captured-byte queue
    initial begin
        logic have_prev = 1'b0, p_rd = 1'b1, p_oe = 1'b1, p_rxf = 1'b1;
        logic p_full = 1'b0, p_awf = 1'b0, p_en = 1'b0;
        int p_size = 0, sz;
        forever begin
            @(negedge wclk);
            #2;
            if (!wrst_n) begin
                check_reset("mon_rst");
                have_prev = 1'b0;
            end else begin
                sz = exp_q.size();
                check("skid_bound", 32'(sz <= 2), 32'(1));
                check("wr_en", 32'(wr_en_o), 32'(sz != 0 && !wr_full_i));
                if (wr_en_o && sz != 0) check("wr_data", 32'(wr_data_o), 32'(exp_q.pop_front()));
                check("rx_count", 32'(rx_count_o), 32'(cap_total % (1 << CNT_W)));
                check("busy", 32'(busy_o), 32'(!ft_oe_n_o || sz != 0));
                if (have_prev) begin
                    if (!p_rd && (p_rxf || p_full || p_awf || !p_en || sz == 2))
                        check("stop", 32'({ft_oe_n_o, ft_rd_n_o}), 32'(3));
                    if (!ft_rd_n_o) check("turnaround", 32'(p_oe), 32'(0));
                    if (p_oe && (p_rxf || p_full || p_awf || !p_en || p_size != 0))
                        check("no_start", 32'(ft_oe_n_o), 32'(1));
                end
                have_prev = 1'b1;
                p_rd = ft_rd_n_o;
                p_oe = ft_oe_n_o;
                p_rxf = ft_rxf_n_i;
                p_full = wr_full_i;
                p_awf = wr_awfull_i;
                p_en = en_i;
                p_size = sz;
            end
        end
    end

    initial begin
        #1 wrst_n = 1'b0;
        #1 check_reset("init_rst");
        repeat (3) cyc();
        wrst_n = 1'b1;
        repeat (2) cyc();

        for (int b = 0; b < 16; b++) host_q.push_back(DSIZE'(b));
        en_i = 1'b1;
        run_idle("burst16", 200);
        check("rx_wrap16", 32'(rx_count_o), 32'(0));

        for (int b = 0; b < 16; b++) host_q.push_back(DSIZE'(b));
        for (int i = 0; i < 100 && host_q.size() > 11; i++) cyc();
        wr_full_i = 1'b1;
        repeat (5) cyc();
        wr_full_i = 1'b0;
        run_idle("full_hold", 200);

        gap_pct = 30;
        for (int b = 0; b < 32; b++) host_q.push_back(DSIZE'($urandom));
        run_idle("rxf_gaps", 500);
        gap_pct = 0;

        for (int b = 0; b < 40; b++) host_q.push_back(DSIZE'($urandom));
        wait_rd("en_drop");
        repeat (3) cyc();
        en_i = 1'b0;
        repeat (10) cyc();
        check("en_hold_oe", 32'(ft_oe_n_o), 32'(1));
        check("en_busy", 32'(busy_o), 32'(0));
        check("en_bytes_left", 32'(host_q.size() > 0), 32'(1));
        en_i = 1'b1;
        run_idle("en_resume", 300);

        for (int b = 0; b < 20; b++) host_q.push_back(DSIZE'($urandom));
        wait_rd("mid_rst");
        repeat (2) cyc();
        wr_full_i = 1'b1;
        repeat (3) cyc();
        check("pre_rst_busy", 32'(busy_o), 32'(1));
        wrst_n = 1'b0;
        will_cap = 1'b0;
        #1 check_reset("mid_rst");
        exp_q.delete();
        cap_total = 0;
        wr_full_i = 1'b0;
        repeat (2) cyc();
        wrst_n = 1'b1;
        run_idle("post_rst", 300);

        thr_pct = 15;
        gap_pct = 15;
        for (int b = 0; b < 64; b++) host_q.push_back(DSIZE'($urandom));
        run_idle("throttle_rand", 3000);
        gap_pct = 0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
